// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle N-bit subtract D = a - b - bin, W bits per cycle, LSB slice first.
// Ports: clk, rst (sync, active-high), start/enable in; a, b, bin operands; busy, done, D, Bout, V out.
module serial_subtractor #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         enable,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         V
);

    localparam int NS = N / W;
    localparam int CW = (NS < 1) ? 1 : $clog2(NS + 1);

    if (N % W != 0) begin : g_bad_w
        $error("serial_subtractor: N must be a multiple of W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_d;
    logic [CW-1:0]  r_cnt;
    logic           r_borrow;
    logic           r_bout;
    logic           r_v;
    logic           r_amsb;
    logic           r_bmsb;
    logic [W:0]     w_sub;
    logic           w_last;

    // Operands shift right each slice, so the live slice is always the low W bits.
    assign w_sub  = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - {{W{1'b0}}, r_borrow};
    // Counter past the last slice: this RUN step latches Bout and V.
    assign w_last = (r_cnt == CW'(NS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN:  if (enable && w_last) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_v      <= 1'b0;
            r_amsb   <= 1'b0;
            r_bmsb   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_amsb   <= a[N-1];
                        r_bmsb   <= b[N-1];
                        r_cnt    <= '0;
                        r_d      <= '0;
                    end
                end
                S_RUN: begin
                    if (enable) begin
                        if (w_last) begin
                            r_bout <= r_borrow;
                            r_v    <= (r_amsb != r_bmsb) && (r_d[N-1] != r_amsb);
                        end else begin
                            for (int k = 0; k < NS; k++) begin
                                if (r_cnt == CW'(k)) begin
                                    r_d[k*W +: W] <= w_sub[W-1:0];
                                end
                            end
                            r_borrow <= w_sub[W];
                            r_a      <= r_a >> W;
                            r_b      <= r_b >> W;
                            r_cnt    <= r_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign D    = r_d;
    assign Bout = r_bout;
    assign V    = r_v;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor (N=16, W=4).
// Expected results come from a full-width reference subtract.
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic        enable;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] D;
    logic        Bout;
    logic        V;

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        v;
    } res_t;

    res_t sbq[$];
    int   n_chk;
    int   n_fail;

    serial_subtractor #(.N(16), .W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .enable (enable),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .D      (D),
        .Bout   (Bout),
        .V      (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        logic [16:0] full;
        res_t r;
        full = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        r.d  = full[15:0];
        r.bo = full[16];
        r.v  = (ma[15] != mb[15]) && (full[15] != ma[15]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic obin,
                          input int st_at, input int st_n, input bit poke, input int exp_lat);
        int   n;
        bit   got;
        res_t e;
        a     = oa;
        b     = ob;
        bin   = obin;
        start = 1'b1;
        enable = 1'b1;
        sbq.push_back(model(oa, ob, obin));
        tick();
        start = 1'b0;
        n     = 0;
        got   = 1'b0;
        while (n < 40 && !got) begin
            enable = !((n + 1) >= st_at && (n + 1) < st_at + st_n);
            if (poke && n == 1) begin
                a     = ~oa;
                b     = ~ob;
                bin   = ~obin;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
            if (done === 1'b1) got = 1'b1;
        end
        enable = 1'b1;
        if (!got) begin
            chk("timeout", 32'd0, 32'd1);
            sbq.delete();
        end else begin
            chk("latency", n, exp_lat);
            chk("busy_at_done", {31'd0, busy}, 32'd1);
            if (sbq.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("D", {16'd0, D}, {16'd0, e.d});
                chk("Bout", {31'd0, Bout}, {31'd0, e.bo});
                chk("V", {31'd0, V}, {31'd0, e.v});
                tick();
                chk("done_pulse", {31'd0, done}, 32'd0);
                chk("busy_idle", {31'd0, busy}, 32'd0);
                chk("D_hold", {16'd0, D}, {16'd0, e.d});
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        enable = 1'b1;
        a      = '0;
        b      = '0;
        bin    = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_D", {16'd0, D}, 32'd0);
        chk("rst_Bout", {31'd0, Bout}, 32'd0);
        chk("rst_V", {31'd0, V}, 32'd0);
        rst = 1'b0;
        tick();

        run_op(16'h0005, 16'h0003, 1'b0, 0, 0, 1'b0, 5);
        run_op(16'h0000, 16'h0001, 1'b0, 0, 0, 1'b0, 5);
        run_op(16'h8000, 16'h0001, 1'b0, 0, 0, 1'b0, 5);
        run_op(16'h1234, 16'h1234, 1'b1, 0, 0, 1'b0, 5);
        run_op(16'h0005, 16'h0003, 1'b0, 2, 3, 1'b0, 8);
        run_op(16'h0005, 16'h0003, 1'b0, 0, 0, 1'b1, 5);
        run_op(16'h7FFF, 16'h8000, 1'b0, 0, 0, 1'b0, 5);

        // Abort an operation mid-RUN; Bout and V are both 1 beforehand.
        a     = 16'h1234;
        b     = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_D", {16'd0, D}, 32'd0);
        chk("mid_rst_Bout", {31'd0, Bout}, 32'd0);
        chk("mid_rst_V", {31'd0, V}, 32'd0);
        tick();
        run_op(16'h0000, 16'h0001, 1'b0, 0, 0, 1'b0, 5);

        for (int i = 0; i < 256; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 0, 0, 1'b0, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
